key_led_bank: RTL and testbench

KEY_LED_BANK -- requirements
Module: key_led_bank

---
 rtl/key_led_pkg.sv | 19 +
 rtl/key_debounce.sv | 71 +++++++
 rtl/key_led_bank.sv | 54 +++++
 tb/tb_key_led_bank.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/key_led_pkg.sv
// Shared constants and helpers for the key/LED bank.
package key_led_pkg;

  localparam int LED_MODE_FOLLOW = 0;
  localparam int LED_MODE_TOGGLE = 1;

  // Registered per-channel events leaving the debouncer.
  typedef struct packed {
    logic state;  // debounced level, 1 = pressed
    logic press;  // one-cycle pulse on accepted press
    logic rel;    // one-cycle pulse on accepted release
  } key_ev_t;

  // Debounce counter width: max(1, clog2(n)); it only ever reaches n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key channel: synchroniser, debounce counter, stable level and
// registered press/release pulses. Everything inside is in "pressed" polarity.
module key_debounce
  import key_led_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int DB_CYCLES      = 1000000,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic    sys_clk,
  input  logic    sys_rst,
  input  logic    key_in,
  output key_ev_t ev,
  output logic    level,      // internal stable level, one cycle ahead of ev.state
  output logic    press_nxt   // value ev.press takes on the next edge
);

  localparam int            CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  // Raw key level when the key is not pressed.
  localparam logic          REL_LVL  = (KEY_ACTIVE_LOW != 0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sample;
  logic [CW-1:0]          cnt_q;
  logic                   stable_q;
  logic                   state_q, press_q, rel_q;

  assign sample    = sync_q[SYNC_STAGES-1] ^ REL_LVL;
  assign level     = stable_q;
  assign press_nxt = stable_q & ~state_q;

  // Synchroniser chain on the raw level; resets to the released level.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) sync_q <= {SYNC_STAGES{REL_LVL}};
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], key_in};
  end

  // Count consecutive differing samples; accept on the DB_CYCLES-th one.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else if (sample == stable_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_q <= sample;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Registered level and edge pulses, all updated on the same edge.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= stable_q;
      press_q <= stable_q & ~state_q;
      rel_q   <= ~stable_q & state_q;
    end
  end

  assign ev.state = state_q;
  assign ev.press = press_q;
  assign ev.rel   = rel_q;

endmodule

// File: rtl/key_led_bank.sv
// Bank of CH independent debounced keys, each driving one LED in follow or
// toggle mode.
module key_led_bank
  import key_led_pkg::*;
#(
  parameter int CH             = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int DB_CYCLES      = 1000000,
  parameter int KEY_ACTIVE_LOW = 1,
  parameter int LED_MODE       = 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic [CH-1:0] key_in,
  output logic [CH-1:0] led_out,
  output logic [CH-1:0] key_press,
  output logic [CH-1:0] key_release,
  output logic [CH-1:0] key_state
);

  key_ev_t [CH-1:0] ev;
  logic    [CH-1:0] level;
  logic    [CH-1:0] press_nxt;
  logic    [CH-1:0] led_q;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    key_debounce #(
      .SYNC_STAGES   (SYNC_STAGES),
      .DB_CYCLES     (DB_CYCLES),
      .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
    ) u_db (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .key_in   (key_in[g]),
      .ev       (ev[g]),
      .level    (level[g]),
      .press_nxt(press_nxt[g])
    );
    assign key_state[g]   = ev[g].state;
    assign key_press[g]   = ev[g].press;
    assign key_release[g] = ev[g].rel;
  end

  // LED register: flips with each press pulse in toggle mode; in follow mode
  // it loads the same level key_state does, so the two stay identical.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)                          led_q <= '0;
    else if (LED_MODE == LED_MODE_TOGGLE) led_q <= led_q ^ press_nxt;
    else                                  led_q <= level;
  end

  assign led_out = led_q;

endmodule

// File: tb/tb_key_led_bank.sv
// Bench for key_led_bank: a toggle-mode and a follow-mode instance share the
// same keys and are checked against a sliding-window model of the debouncer.
module tb_key_led_bank;
  localparam int CH = 2, S = 2, DB = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [CH-1:0] key_in  = '1;
  logic [CH-1:0] t_led, t_pr, t_rl, t_st;
  logic [CH-1:0] f_led, f_pr, f_rl, f_st;

  key_led_bank #(.CH(CH), .SYNC_STAGES(S), .DB_CYCLES(DB), .KEY_ACTIVE_LOW(1), .LED_MODE(1)) dut_t (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .key_in(key_in),
    .led_out(t_led), .key_press(t_pr), .key_release(t_rl), .key_state(t_st));

  key_led_bank #(.CH(CH), .SYNC_STAGES(S), .DB_CYCLES(DB), .KEY_ACTIVE_LOW(1), .LED_MODE(0)) dut_f (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .key_in(key_in),
    .led_out(f_led), .key_press(f_pr), .key_release(f_rl), .key_state(f_st));

  always #5 sys_clk = ~sys_clk;

  int ntest = 0, nfail = 0;

  // Model: per-edge history of captured pressed levels. A channel's level flips
  // at edge m when the captures from edges m-S-DB+1 .. m-S all differ from it;
  // the outputs show that level one edge later.
  logic [CH-1:0] hist[$];
  logic [CH-1:0] m_stb, m_st, m_pr, m_rl, m_led;

  logic [8*CH-1:0] got, exp;
  assign got = {t_led, t_pr, t_rl, t_st, f_led, f_pr, f_rl, f_st};
  assign exp = {m_led, m_pr, m_rl, m_st, m_st, m_pr, m_rl, m_st};

  task automatic model_reset();
    hist.delete();
    repeat (S + DB) hist.push_back('0);
    m_stb = '0; m_st = '0; m_pr = '0; m_rl = '0; m_led = '0;
  endtask

  // Drive keys, advance one edge (model included), stop at the next negedge.
  task automatic tick(input logic [CH-1:0] kin);
    logic [CH-1:0] nxt, h;
    logic dif;
    key_in = kin;
    @(posedge sys_clk);
    if (sys_rst) model_reset();
    else begin
      hist.push_back(~kin);
      void'(hist.pop_front());
      nxt = m_stb;
      for (int c = 0; c < CH; c++) begin
        dif = 1'b1;
        for (int k = 0; k < DB; k++) begin
          h = hist[hist.size() - 1 - S - k];
          if (h[c] == m_stb[c]) dif = 1'b0;
        end
        if (dif) nxt[c] = ~m_stb[c];
      end
      m_pr  = m_stb & ~m_st;
      m_rl  = ~m_stb & m_st;
      m_led = m_led ^ m_pr;
      m_st  = m_stb;
      m_stb = nxt;
    end
    @(negedge sys_clk);
  endtask

  task automatic do_reset(input logic [CH-1:0] kin);
    sys_rst = 1'b1;
    model_reset();
    repeat (2) tick(kin);
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    model_reset();
    #1;
    ntest++; if (got !== '0) begin nfail++; $display("FAIL reset_async got %h exp 0", got); end
    repeat (3) begin
      tick(2'b00);
      ntest++; if (got !== '0) begin nfail++; $display("FAIL reset_hold got %h exp 0", got); end
    end
    sys_rst = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick(2'b00);
      ntest++; if (got !== exp) begin nfail++; $display("FAIL reset_model e%0d got %h exp %h", e, got, exp); end
      ntest++; if (t_pr !== ((e == 6) ? 2'b11 : 2'b00)) begin nfail++; $display("FAIL reset_press e%0d got %b", e, t_pr); end
    end
    ntest++; if (t_st !== 2'b11) begin nfail++; $display("FAIL reset_state got %b exp 11", t_st); end
  endtask

  task automatic test_toggle();
    do_reset(2'b11);
    repeat (4) tick(2'b11);
    for (int e = 0; e < 10; e++) begin
      tick(2'b10);
      ntest++; if (got !== exp) begin nfail++; $display("FAIL toggle_model p1 e%0d got %h exp %h", e, got, exp); end
      ntest++; if (t_pr[0] !== (e == 6) || t_led[0] !== (e >= 6)) begin nfail++; $display("FAIL toggle_press e%0d pr %b led %b", e, t_pr[0], t_led[0]); end
    end
    for (int e = 0; e < 10; e++) begin
      tick(2'b11);
      ntest++; if (got !== exp) begin nfail++; $display("FAIL toggle_model r e%0d got %h exp %h", e, got, exp); end
      ntest++; if (t_rl[0] !== (e == 6) || t_led[0] !== 1'b1) begin nfail++; $display("FAIL toggle_release e%0d rl %b led %b", e, t_rl[0], t_led[0]); end
    end
    for (int e = 0; e < 10; e++) begin
      tick(2'b10);
      ntest++; if (got !== exp) begin nfail++; $display("FAIL toggle_model p2 e%0d got %h exp %h", e, got, exp); end
      ntest++; if (t_led[0] !== (e < 6)) begin nfail++; $display("FAIL toggle_second e%0d led %b exp %b", e, t_led[0], (e < 6)); end
    end
  endtask

  task automatic test_bounce();
    logic [15:0] pat;
    pat = 16'b1111_1111_1000_1000;  // LSB first: 0,0,0,1,0,0,0,1,1...
    do_reset(2'b11);
    repeat (6) tick(2'b11);
    for (int e = 0; e < 16; e++) begin
      tick({1'b1, pat[e]});
      ntest++; if (got !== exp) begin nfail++; $display("FAIL bounce_model e%0d got %h exp %h", e, got, exp); end
      ntest++; if ({t_pr, t_st, t_led, f_led} !== '0) begin nfail++; $display("FAIL bounce_quiet e%0d got %b exp 0", e, {t_pr, t_st, t_led, f_led}); end
    end
  endtask

  task automatic test_follow();
    do_reset(2'b11);
    repeat (4) tick(2'b11);
    for (int e = 0; e < 12; e++) begin
      tick(2'b01);
      ntest++; if (got !== exp) begin nfail++; $display("FAIL follow_model p e%0d got %h exp %h", e, got, exp); end
      ntest++; if (f_led[1] !== (e >= 6)) begin nfail++; $display("FAIL follow_on e%0d led %b exp %b", e, f_led[1], (e >= 6)); end
    end
    for (int e = 0; e < 10; e++) begin
      tick(2'b11);
      ntest++; if (got !== exp) begin nfail++; $display("FAIL follow_model r e%0d got %h exp %h", e, got, exp); end
      ntest++; if (f_led[1] !== (e < 6)) begin nfail++; $display("FAIL follow_off e%0d led %b exp %b", e, f_led[1], (e < 6)); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(2'b11);
    repeat (4) tick(2'b11);
    repeat (4) begin
      tick(2'b10);
      ntest++; if (t_pr !== 2'b00) begin nfail++; $display("FAIL midrst_pre got %b exp 00", t_pr); end
    end
    sys_rst = 1'b1;
    model_reset();
    repeat (2) begin
      tick(2'b10);
      ntest++; if (got !== '0) begin nfail++; $display("FAIL midrst_hold got %h exp 0", got); end
    end
    sys_rst = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick(2'b10);
      ntest++; if (got !== exp) begin nfail++; $display("FAIL midrst_model e%0d got %h exp %h", e, got, exp); end
      ntest++; if (t_pr[0] !== (e == 6)) begin nfail++; $display("FAIL midrst_press e%0d got %b exp %b", e, t_pr[0], (e == 6)); end
    end
  endtask

  task automatic test_random();
    logic [CH-1:0] kin;
    int hold;
    do_reset(2'b11);
    for (int n = 0; n < 120; n++) begin
      kin  = CH'($urandom);
      hold = $urandom_range(1, 9);
      repeat (hold) begin
        tick(kin);
        ntest++; if (got !== exp) begin nfail++; $display("FAIL random_model n%0d got %h exp %h", n, got, exp); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_bounce();
    test_follow();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
